// File: rtl/seq_signed_div.sv
// ============================================================================
// Module   : seq_signed_div
// Function : Sequential N-bit signed divider (restoring, one quotient bit per
//            cycle) with valid/ready handshakes and divide-by-zero/overflow flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_signed_div #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_zero,
  output logic         ovf
);

  localparam int            CW     = $clog2(N);
  localparam logic [N-1:0]  C_MIN  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]  C_MAX  = ~C_MIN;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N:0]    rem_q, rem_d;
  logic [N-1:0]  divmag_q, divmag_d;
  logic          sa_q, sa_d;
  logic          sb_q, sb_d;
  logic [N-1:0]  quotient_q, quotient_d;
  logic [N-1:0]  remainder_q, remainder_d;
  logic          div_zero_q, div_zero_d;
  logic          ovf_q, ovf_d;

  logic [N-1:0]  w_a_mag;
  logic [N-1:0]  w_b_mag;
  logic [N:0]    w_shift;
  logic [N:0]    w_sub;
  logic          w_ge;

  // The magnitude of the most negative value is 2^(N-1), which still fits unsigned.
  assign w_a_mag = dividend[N-1] ? -dividend : dividend;
  assign w_b_mag = divisor[N-1]  ? -divisor  : divisor;

  // quo_q starts as the dividend magnitude and is shifted out MSB first while
  // quotient bits shift in from the bottom.
  assign w_shift = (rem_q << 1) | {{N{1'b0}}, quo_q[N-1]};
  assign w_sub   = w_shift - {1'b0, divmag_q};
  assign w_ge    = (w_shift >= {1'b0, divmag_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      divmag_q    <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      divmag_q    <= divmag_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    divmag_d    = divmag_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    ovf_d       = ovf_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sa_d       = dividend[N-1];
          sb_d       = divisor[N-1];
          quo_d      = w_a_mag;
          divmag_d   = w_b_mag;
          rem_d      = '0;
          cnt_d      = '0;
          div_zero_d = 1'b0;
          ovf_d      = (dividend == C_MIN) && (divisor == '1);
          if (divisor == '0) begin
            div_zero_d  = 1'b1;
            ovf_d       = 1'b0;
            quotient_d  = dividend[N-1] ? C_MIN : C_MAX;
            remainder_d = dividend;
            state_d     = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = w_ge ? w_sub : w_shift;
        quo_d = {quo_q[N-2:0], w_ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quotient_d  = (sa_q ^ sb_q) ? -quo_q : quo_q;
        remainder_d = sa_q ? -rem_q[N-1:0] : rem_q[N-1:0];
        state_d     = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_signed_div.sv
// ============================================================================
// Module   : tb_seq_signed_div
// Function : Directed, table-driven self-checking bench for seq_signed_div.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_signed_div;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_zero;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    logic         ov;
    int           lat;
  } vec_t;

  vec_t tbl[13];

  seq_signed_div #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Offer one pair, measure latency to out_valid, and check the results.
  // Leaves the DUT in DONE with out_ready low.
  task automatic run_div(input vec_t v);
    int  lat;
    bit  got;
    @(negedge clk);
    dividend = v.a;
    divisor  = v.b;
    in_valid = 1'b1;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'(($urandom));
    divisor  = 16'(($urandom));
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    chk("latency", 32'(lat), 32'(v.lat));
    chk("quotient", 32'(quotient), 32'(v.q));
    chk("remainder", 32'(remainder), 32'(v.r));
    chk("div_zero", 32'(div_zero), 32'(v.dz));
    chk("ovf", 32'(ovf), 32'(v.ov));
    chk("in_ready_in_done", 32'(in_ready), 32'd0);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [N-1:0] hq, hr;
    logic         hdz, hov;
    bit           seen;
    vec_t         v;

    tbl[0]  = '{16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 17};
    tbl[1]  = '{16'(-100), 16'd7, 16'(-14), 16'(-2), 1'b0, 1'b0, 17};
    tbl[2]  = '{16'd100, 16'(-7), 16'(-14), 16'd2, 1'b0, 1'b0, 17};
    tbl[3]  = '{16'(-100), 16'(-7), 16'd14, 16'(-2), 1'b0, 1'b0, 17};
    tbl[4]  = '{16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 1'b1, 17};
    tbl[5]  = '{16'h8000, 16'd1, 16'h8000, 16'd0, 1'b0, 1'b0, 17};
    tbl[6]  = '{16'd5, 16'd0, 16'd32767, 16'd5, 1'b1, 1'b0, 1};
    tbl[7]  = '{16'(-5), 16'd0, 16'h8000, 16'(-5), 1'b1, 1'b0, 1};
    tbl[8]  = '{16'd32767, 16'h8000, 16'd0, 16'd32767, 1'b0, 1'b0, 17};
    tbl[9]  = '{16'h8000, 16'd32767, 16'(-1), 16'(-1), 1'b0, 1'b0, 17};
    tbl[10] = '{16'd7, 16'd100, 16'd0, 16'd7, 1'b0, 1'b0, 17};
    tbl[11] = '{16'h8000, 16'h8000, 16'd1, 16'd0, 1'b0, 1'b0, 17};
    tbl[12] = '{16'd0, 16'd0, 16'd32767, 16'd0, 1'b1, 1'b0, 1};

    // Reset with in_valid held high: reset must win.
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    dividend  = 16'd50;
    divisor   = 16'd5;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_flags", {30'd0, div_zero, ovf}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      run_div(tbl[i]);
      release_out();
    end

    // Back-pressure: results held while out_ready stays low.
    v = '{16'd1000, 16'(-33), 16'(-30), 16'd10, 1'b0, 1'b0, 17};
    run_div(v);
    hq  = quotient;
    hr  = remainder;
    hdz = div_zero;
    hov = ovf;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_quotient", 32'(quotient), 32'(hq));
      chk("hold_remainder", 32'(remainder), 32'(hr));
      chk("hold_flags", {30'd0, div_zero, ovf}, {30'd0, hdz, hov});
    end
    release_out();

    // Reset in the middle of CALC aborts the operation.
    @(negedge clk);
    dividend = 16'd1000;
    divisor  = 16'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_flags", {30'd0, div_zero, ovf}, 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_out_valid", 32'(seen), 32'd0);

    v = '{16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 1'b0, 17};
    run_div(v);
    release_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
